// File: rtl/dm_abstract_ctl.sv
// Debug Module abstract-command controller: DMI register decode, hart halt/resume, abstract command sequencing.
// Latency: dmi_ack and dmi_rdata are registered one cycle after dmi_req; register side effects are visible in the ack cycle.
// Backpressure: none on DMI (every request is acked); hart side is a level exec held until done is seen.
//
// Optional feature: define DM_AUTOEXEC_EN to implement abstractauto (0x18) and auto-execution
// on data/progbuf accesses. Without it, 0x18 reads 0 and ignores writes.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   dmi_req/we/addr/wdata       single-cycle DMI access from the DTM
//   dmi_rdata/dmi_ack           response, one cycle after dmi_req
//   halt_req/resume_req         level requests to the hart
//   command/exec                latched abstract command and in-flight flag
//   data_out/progbuf_out        data and program buffer registers, packed 32 bits per word
//   halted                      hart halted status
//   done/write/wdata            command completion, optional data0 result write
//   exception/bus/haltresume    completion error qualifiers (sampled with done)

module dm_abstract_ctl #(
  parameter int DATA_COUNT   = 2,
  parameter int PROGBUF_SIZE = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dmi_req,
  input  logic                         dmi_we,
  input  logic [6:0]                   dmi_addr,
  input  logic [31:0]                  dmi_wdata,
  output logic [31:0]                  dmi_rdata,
  output logic                         dmi_ack,
  output logic                         halt_req,
  output logic                         resume_req,
  output logic [31:0]                  command,
  output logic                         exec,
  output logic [DATA_COUNT*32-1:0]     data_out,
  output logic [PROGBUF_SIZE*32-1:0]   progbuf_out,
  input  logic                         halted,
  input  logic                         done,
  input  logic                         write,
  input  logic [31:0]                  wdata,
  input  logic                         exception,
  input  logic                         bus,
  input  logic                         haltresume
);

  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;
  localparam logic [6:0] ADDR_PROGBUF0   = 7'h20;
`ifdef DM_AUTOEXEC_EN
  localparam logic [6:0] ADDR_ABSTRACTAUTO = 7'h18;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      state;
  logic        dmactive;
  logic        resumeack;
  logic [2:0]  cmderr;
  logic [31:0] data_q    [DATA_COUNT];
  logic [31:0] progbuf_q [PROGBUF_SIZE];
`ifdef DM_AUTOEXEC_EN
  logic [DATA_COUNT-1:0]   auto_data;
  logic [PROGBUF_SIZE-1:0] auto_pb;
`endif

  // Next-state values
  logic [2:0]  cmderr_n;
  logic [31:0] data_n    [DATA_COUNT];
  logic [31:0] progbuf_n [PROGBUF_SIZE];
  logic [31:0] cmd_n;
  logic [31:0] cand;
  logic [31:0] rdata_n;
  logic        issue;

  logic                    dmc_wr;
  logic                    active_nxt;
  logic                    acc;
  logic                    busy;
  logic                    done_hit;
  logic                    cmd_wr;
  logic                    reg_wr;
  logic                    auto_hit;
  logic [DATA_COUNT-1:0]   data_hit;
  logic [PROGBUF_SIZE-1:0] pb_hit;

  // A dmcontrol write takes dmactive from the written value, so a single write can
  // both activate the DM and raise haltreq/resumereq.
  assign dmc_wr     = dmi_req & dmi_we & (dmi_addr == ADDR_DMCONTROL);
  assign active_nxt = dmc_wr ? dmi_wdata[0] : dmactive;
  assign acc        = dmi_req & dmactive;
  assign busy       = (state == S_BUSY);
  assign done_hit   = busy & done;
  assign cmd_wr     = acc & dmi_we & (dmi_addr == ADDR_COMMAND);
  assign reg_wr     = acc & dmi_we & ((|data_hit) | (|pb_hit));

  always_comb begin
    data_hit = '0;
    pb_hit   = '0;
    for (int i = 0; i < DATA_COUNT; i++)
      data_hit[i] = (dmi_addr == 7'(ADDR_DATA0 + i));
    for (int i = 0; i < PROGBUF_SIZE; i++)
      pb_hit[i] = (dmi_addr == 7'(ADDR_PROGBUF0 + i));
  end

`ifdef DM_AUTOEXEC_EN
  assign auto_hit = acc & ((|(data_hit & auto_data)) | (|(pb_hit & auto_pb)));
`else
  assign auto_hit = 1'b0;
`endif

  // Abstract command bookkeeping. Statement order sets priority: cmderr W1C first, then
  // completion errors, then DMI-side errors; the hart data0 write lands last so it
  // overrides a same-cycle DMI data0 write. cmderr only ever records the first error.
  always_comb begin
    cmderr_n  = cmderr;
    data_n    = data_q;
    progbuf_n = progbuf_q;
    cmd_n     = command;
    issue     = 1'b0;
    cand      = cmd_wr ? dmi_wdata : command;

    if (acc && dmi_we && dmi_addr == ADDR_ABSTRACTCS)
      cmderr_n = cmderr & ~dmi_wdata[10:8];

    if (done_hit && cmderr_n == 3'd0) begin
      if (bus)             cmderr_n = 3'd5;
      else if (exception)  cmderr_n = 3'd3;
      else if (haltresume) cmderr_n = 3'd4;
    end

    if (reg_wr) begin
      if (busy) begin
        if (cmderr_n == 3'd0) cmderr_n = 3'd1;
      end else begin
        for (int i = 0; i < DATA_COUNT; i++)
          if (data_hit[i]) data_n[i] = dmi_wdata;
        for (int i = 0; i < PROGBUF_SIZE; i++)
          if (pb_hit[i]) progbuf_n[i] = dmi_wdata;
      end
    end

    // Explicit command writes and auto-execution share one acceptance path.
    if (cmd_wr || auto_hit) begin
      if (cmderr_n != 3'd0) begin
        // sticky error: request dropped
      end else if (busy) begin
        cmderr_n = 3'd1;
      end else if (cand[31:24] > 8'd2) begin
        cmderr_n = 3'd2;
      end else if ((cand[31:24] == 8'd1) == halted) begin
        // access register / memory need a halted hart; quick access needs it running
        cmderr_n = 3'd4;
      end else begin
        issue = 1'b1;
        cmd_n = cand;
      end
    end

    if (done_hit && write && !bus && !exception)
      data_n[0] = wdata;
  end

  // DMI read mux, sampled into dmi_rdata with the ack.
  always_comb begin
    rdata_n = '0;
    case (dmi_addr)
      ADDR_DMCONTROL:  rdata_n = {halt_req, 30'b0, dmactive};
      ADDR_DMSTATUS:   rdata_n = {14'b0, resumeack, resumeack, 4'b0, ~halted, ~halted,
                                  halted, halted, 1'b1, 3'b0, 4'd2};
      ADDR_ABSTRACTCS: rdata_n = {3'b0, 5'(PROGBUF_SIZE), 11'b0, busy, 1'b0, cmderr,
                                  4'b0, 4'(DATA_COUNT)};
`ifdef DM_AUTOEXEC_EN
      ADDR_ABSTRACTAUTO: begin
        rdata_n[DATA_COUNT-1:0]     = auto_data;
        rdata_n[16 +: PROGBUF_SIZE] = auto_pb;
      end
`endif
      default: begin
        for (int i = 0; i < DATA_COUNT; i++)
          if (data_hit[i]) rdata_n = data_q[i];
        for (int i = 0; i < PROGBUF_SIZE; i++)
          if (pb_hit[i]) rdata_n = progbuf_q[i];
      end
    endcase
  end

  // Register file and hart request levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmi_ack    <= 1'b0;
      dmi_rdata  <= '0;
      dmactive   <= 1'b0;
      halt_req   <= 1'b0;
      resume_req <= 1'b0;
      resumeack  <= 1'b0;
      cmderr     <= '0;
      command    <= '0;
      data_q     <= '{default: '0};
      progbuf_q  <= '{default: '0};
`ifdef DM_AUTOEXEC_EN
      auto_data  <= '0;
      auto_pb    <= '0;
`endif
    end else begin
      dmi_ack   <= dmi_req;
      dmi_rdata <= dmi_req ? rdata_n : '0;
      dmactive  <= active_nxt;
      if (!active_nxt) begin
        halt_req   <= 1'b0;
        resume_req <= 1'b0;
        resumeack  <= 1'b0;
        cmderr     <= '0;
        command    <= '0;
        data_q     <= '{default: '0};
        progbuf_q  <= '{default: '0};
`ifdef DM_AUTOEXEC_EN
        auto_data  <= '0;
        auto_pb    <= '0;
`endif
      end else begin
        if (dmc_wr)
          halt_req <= dmi_wdata[31];
        // resume_req doubles as the resume-pending flag
        if (dmc_wr && dmi_wdata[30] && !dmi_wdata[31]) begin
          resume_req <= 1'b1;
          resumeack  <= 1'b0;
        end else if (resume_req && !halted) begin
          resume_req <= 1'b0;
          resumeack  <= 1'b1;
        end
        cmderr    <= cmderr_n;
        command   <= cmd_n;
        data_q    <= data_n;
        progbuf_q <= progbuf_n;
`ifdef DM_AUTOEXEC_EN
        if (acc && dmi_we && dmi_addr == ADDR_ABSTRACTAUTO) begin
          auto_data <= dmi_wdata[DATA_COUNT-1:0];
          auto_pb   <= dmi_wdata[16 +: PROGBUF_SIZE];
        end
`endif
      end
    end
  end

  // Command FSM: exec is a registered copy of BUSY, so it rises with the ack of the
  // accepted write and falls the cycle after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      exec  <= 1'b0;
    end else if (!active_nxt) begin
      state <= S_IDLE;
      exec  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (issue) begin
          state <= S_BUSY;
          exec  <= 1'b1;
        end
        S_BUSY: if (done) begin
          state <= S_IDLE;
          exec  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          exec  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < DATA_COUNT; g++) begin : g_data
    assign data_out[g*32 +: 32] = data_q[g];
  end
  for (genvar g = 0; g < PROGBUF_SIZE; g++) begin : g_pb
    assign progbuf_out[g*32 +: 32] = progbuf_q[g];
  end

endmodule

// File: tb/tb_dm_abstract_ctl.sv
module tb_dm_abstract_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmi_req, dmi_we;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata, dmi_rdata;
  logic        dmi_ack, halt_req, resume_req, exec;
  logic [31:0] command;
  logic [63:0] data_out, progbuf_out;
  logic        halted, done, write, exception, bus, haltresume;
  logic [31:0] wdata;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dm_abstract_ctl #(.DATA_COUNT(2), .PROGBUF_SIZE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .dmi_req(dmi_req), .dmi_we(dmi_we), .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata),
    .dmi_rdata(dmi_rdata), .dmi_ack(dmi_ack),
    .halt_req(halt_req), .resume_req(resume_req), .command(command), .exec(exec),
    .data_out(data_out), .progbuf_out(progbuf_out),
    .halted(halted), .done(done), .write(write), .wdata(wdata),
    .exception(exception), .bus(bus), .haltresume(haltresume)
  );

  // One DMI access; returns at the falling edge inside the ack cycle.
  task automatic dmi(input logic we, input logic [6:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic ack);
    @(negedge clk);
    dmi_req = 1'b1; dmi_we = we; dmi_addr = a; dmi_wdata = d;
    @(negedge clk);
    dmi_req = 1'b0; dmi_we = 1'b0; dmi_addr = '0; dmi_wdata = '0;
    rd  = dmi_rdata;
    ack = dmi_ack;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic k;
    dmi(1'b1, a, d, r, k);
  endtask

  task automatic rd(input logic [6:0] a, output logic [31:0] r);
    logic k;
    dmi(1'b0, a, 32'h0, r, k);
  endtask

  task automatic pulse_done(input logic b, input logic e, input logic h, input logic w,
                            input logic [31:0] d);
    @(negedge clk);
    done = 1'b1; bus = b; exception = e; haltresume = h; write = w; wdata = d;
    @(negedge clk);
    done = 1'b0; bus = 1'b0; exception = 1'b0; haltresume = 1'b0; write = 1'b0; wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if ({halt_req, resume_req, exec, dmi_ack} !== 4'b0) begin
      failed++; $display("FAIL reset_ctl: got %b expected 0000", {halt_req, resume_req, exec, dmi_ack}); end
    tests++; if (command !== 32'h0 || dmi_rdata !== 32'h0) begin
      failed++; $display("FAIL reset_cmd: got %h/%h expected 0", command, dmi_rdata); end
    tests++; if (data_out !== 64'h0 || progbuf_out !== 64'h0) begin
      failed++; $display("FAIL reset_regs: got %h/%h expected 0", data_out, progbuf_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_halt();
    logic [31:0] r;
    logic k;
    halted = 1'b0;
    dmi(1'b1, 7'h10, 32'h8000_0001, r, k);
    tests++; if (k !== 1'b1) begin failed++; $display("FAIL dmi_ack: got %b expected 1", k); end
    tests++; if (halt_req !== 1'b1) begin failed++; $display("FAIL halt_req: got %b expected 1", halt_req); end
    halted = 1'b1;
    rd(7'h11, r);
    tests++; if (r !== 32'h0000_0382) begin failed++; $display("FAIL dmstatus_halted: got %h expected 00000382", r); end
  endtask

  task automatic test_resume();
    logic [31:0] r;
    wr(7'h10, 32'h4000_0001);
    tests++; if ({resume_req, halt_req} !== 2'b10) begin
      failed++; $display("FAIL resume_req: got %b expected 10", {resume_req, halt_req}); end
    halted = 1'b0;
    @(negedge clk);
    tests++; if (resume_req !== 1'b0) begin failed++; $display("FAIL resume_clear: got %b expected 0", resume_req); end
    rd(7'h11, r);
    tests++; if (r !== 32'h0003_0C82) begin failed++; $display("FAIL dmstatus_resumeack: got %h expected 00030c82", r); end
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_0002) begin failed++; $display("FAIL abstractcs_idle: got %h expected 02000002", r); end
  endtask

  task automatic test_command();
    logic [31:0] r;
    halted = 1'b1;
    wr(7'h17, 32'h0022_1008);
    tests++; if (exec !== 1'b1 || command !== 32'h0022_1008) begin
      failed++; $display("FAIL cmd_issue: got exec=%b cmd=%h expected 1/00221008", exec, command); end
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_1002) begin failed++; $display("FAIL cmd_busy: got %h expected 02001002", r); end
    pulse_done(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    tests++; if (exec !== 1'b0 || data_out[31:0] !== 32'hDEAD_BEEF) begin
      failed++; $display("FAIL cmd_done: got exec=%b data0=%h expected 0/deadbeef", exec, data_out[31:0]); end
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_0002) begin failed++; $display("FAIL cmd_idle: got %h expected 02000002", r); end
    rd(7'h04, r);
    tests++; if (r !== 32'hDEAD_BEEF) begin failed++; $display("FAIL data0_read: got %h expected deadbeef", r); end
  endtask

  task automatic test_not_halted();
    logic [31:0] r;
    halted = 1'b0;
    wr(7'h17, 32'h0022_1008);
    @(negedge clk);
    tests++; if (exec !== 1'b0) begin failed++; $display("FAIL running_exec: got %b expected 0", exec); end
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_0402) begin failed++; $display("FAIL running_cmderr: got %h expected 02000402", r); end
    wr(7'h16, 32'h0000_0700);
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_0002) begin failed++; $display("FAIL cmderr_w1c: got %h expected 02000002", r); end
    halted = 1'b1;
  endtask

  task automatic test_busy_err();
    logic [31:0] r;
    wr(7'h17, 32'h0022_1008);
    wr(7'h17, 32'h0022_1008);
    wr(7'h05, 32'h5555_5555);
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_1102) begin failed++; $display("FAIL busy_cmderr: got %h expected 02001102", r); end
    pulse_done(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
    tests++; if (exec !== 1'b0 || data_out !== 64'h0000_0000_DEAD_BEEF) begin
      failed++; $display("FAIL busy_exc_data: got exec=%b data=%h expected 0/00000000deadbeef", exec, data_out); end
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_0102) begin failed++; $display("FAIL busy_sticky: got %h expected 02000102", r); end
    wr(7'h16, 32'h0000_0700);
  endtask

  task automatic test_err_priority();
    logic [31:0] r;
    wr(7'h17, 32'h0022_1008);
    pulse_done(1'b1, 1'b1, 1'b0, 1'b1, 32'h1111_1111);
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_0502 || data_out[31:0] !== 32'hDEAD_BEEF) begin
      failed++; $display("FAIL err_bus: got %h data0=%h expected 02000502/deadbeef", r, data_out[31:0]); end
    wr(7'h16, 32'h0000_0700);
    wr(7'h17, 32'h0022_1008);
    pulse_done(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_0302) begin failed++; $display("FAIL err_exception: got %h expected 02000302", r); end
    wr(7'h16, 32'h0000_0700);
    wr(7'h17, 32'h0022_1008);
    pulse_done(1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D);
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_0402 || data_out[31:0] !== 32'hCAFE_F00D) begin
      failed++; $display("FAIL err_haltresume: got %h data0=%h expected 02000402/cafef00d", r, data_out[31:0]); end
    wr(7'h16, 32'h0000_0700);
  endtask

  task automatic test_cmdtype();
    logic [31:0] r;
    wr(7'h17, 32'h0300_0000);
    tests++; if (exec !== 1'b0) begin failed++; $display("FAIL badtype_exec: got %b expected 0", exec); end
    wr(7'h16, 32'h0000_0100);
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_0202) begin failed++; $display("FAIL badtype_cmderr: got %h expected 02000202", r); end
    wr(7'h16, 32'h0000_0200);
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_0002) begin failed++; $display("FAIL w1c_bit: got %h expected 02000002", r); end
  endtask

  task automatic test_quick();
    logic [31:0] r;
    wr(7'h17, 32'h0100_0000);
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_0402 || exec !== 1'b0) begin
      failed++; $display("FAIL quick_halted: got %h exec=%b expected 02000402/0", r, exec); end
    wr(7'h16, 32'h0000_0700);
    halted = 1'b0;
    wr(7'h17, 32'h0100_0000);
    tests++; if (exec !== 1'b1 || command !== 32'h0100_0000) begin
      failed++; $display("FAIL quick_issue: got exec=%b cmd=%h expected 1/01000000", exec, command); end
    pulse_done(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tests++; if (exec !== 1'b0) begin failed++; $display("FAIL quick_done: got %b expected 0", exec); end
    halted = 1'b1;
  endtask

  task automatic test_regs();
    logic [31:0] r;
    wr(7'h05, 32'h1122_3344);
    wr(7'h21, 32'hA5A5_A5A5);
    tests++; if (data_out[63:32] !== 32'h1122_3344 || progbuf_out !== 64'hA5A5_A5A5_0000_0000) begin
      failed++; $display("FAIL reg_write: got %h/%h expected 11223344/a5a5a5a500000000", data_out[63:32], progbuf_out); end
    rd(7'h21, r);
    tests++; if (r !== 32'hA5A5_A5A5) begin failed++; $display("FAIL progbuf1_read: got %h expected a5a5a5a5", r); end
    wr(7'h30, 32'hFFFF_FFFF);
    rd(7'h30, r);
    tests++; if (r !== 32'h0) begin failed++; $display("FAIL unmapped_read: got %h expected 0", r); end
    rd(7'h10, r);
    tests++; if (r !== 32'h0000_0001) begin failed++; $display("FAIL dmcontrol_read: got %h expected 00000001", r); end
  endtask

  task automatic test_dmactive();
    logic [31:0] r;
    wr(7'h10, 32'h0);
    tests++; if (data_out !== 64'h0 || progbuf_out !== 64'h0 || command !== 32'h0) begin
      failed++; $display("FAIL inactive_clear: got %h/%h/%h expected 0", data_out, progbuf_out, command); end
    wr(7'h04, 32'h1234_5678);
    wr(7'h10, 32'h0000_0001);
    tests++; if (data_out !== 64'h0) begin failed++; $display("FAIL inactive_write: got %h expected 0", data_out); end
  endtask

  task automatic test_autoexec();
    logic [31:0] r;
    halted = 1'b1;
    wr(7'h17, 32'h0022_1008);
    pulse_done(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    wr(7'h18, 32'h0000_0001);
    rd(7'h18, r);
`ifdef DM_AUTOEXEC_EN
    tests++; if (r !== 32'h0000_0001) begin failed++; $display("FAIL auto_reg: got %h expected 00000001", r); end
    rd(7'h04, r);
    tests++; if (exec !== 1'b1 || command !== 32'h0022_1008) begin
      failed++; $display("FAIL auto_issue: got exec=%b cmd=%h expected 1/00221008", exec, command); end
    rd(7'h04, r);
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_1102) begin failed++; $display("FAIL auto_busy: got %h expected 02001102", r); end
`else
    tests++; if (r !== 32'h0) begin failed++; $display("FAIL auto_reg_absent: got %h expected 0", r); end
    rd(7'h04, r);
    tests++; if (exec !== 1'b0) begin failed++; $display("FAIL auto_absent: got %b expected 0", exec); end
    wr(7'h17, 32'h0022_1008);
    tests++; if (exec !== 1'b1) begin failed++; $display("FAIL reissue: got %b expected 1", exec); end
`endif
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] r;
    wr(7'h10, 32'h8000_0001);
    tests++; if ({exec, halt_req} !== 2'b11) begin failed++; $display("FAIL pre_reset: got %b expected 11", {exec, halt_req}); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({exec, halt_req, resume_req, dmi_ack} !== 4'b0 || command !== 32'h0 || data_out !== 64'h0) begin
      failed++; $display("FAIL async_reset: got %b cmd=%h data=%h expected 0", {exec, halt_req, resume_req, dmi_ack}, command, data_out); end
    @(negedge clk);
    rst_n = 1'b1;
    rd(7'h16, r);
    tests++; if (r !== 32'h0200_0002) begin failed++; $display("FAIL post_reset_idle: got %h expected 02000002", r); end
  endtask

  initial begin
    dmi_req = 1'b0; dmi_we = 1'b0; dmi_addr = '0; dmi_wdata = '0;
    halted = 1'b0; done = 1'b0; write = 1'b0; wdata = '0;
    exception = 1'b0; bus = 1'b0; haltresume = 1'b0;
    test_reset();
    test_halt();
    test_resume();
    test_command();
    test_not_halted();
    test_busy_err();
    test_err_priority();
    test_cmdtype();
    test_quick();
    test_regs();
    test_dmactive();
    test_autoexec();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
